// File: rtl/aqed_fc_tracker.sv
// ============================================================================
// Module   : aqed_fc_tracker
// Purpose  : A-QED functional-consistency tracker: batch budget, sequence
//            tracking and orig/dup capture-and-compare for formal harnesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aqed_fc_tracker #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter int SEQ_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [CNT_W-1:0]  depth,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              exec_orig,
    input  logic              exec_dup,
    input  logic              out_valid,
    input  logic [DATA_W-1:0] out_data,
    output logic              in_allow,
    output logic              out_allow,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [1:0]        fsm_state,
    output logic              qed_done,
    output logic              qed_check
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ORIG = 2'd1,
        S_DUP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [SEQ_W-1:0] C_SEQ_MAX = '1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_in_cnt;
    logic [CNT_W-1:0]    r_out_cnt;
    logic [SEQ_W-1:0]    r_in_seq;
    logic [SEQ_W-1:0]    r_out_seq;
    logic [DATA_W-1:0]   r_orig_data;
    logic [SEQ_W-1:0]    r_orig_seq;
    logic [SEQ_W-1:0]    r_dup_seq;
    logic [DATA_W-1:0]   r_orig_out;
    logic [DATA_W-1:0]   r_dup_out;
    logic                r_orig_got;
    logic                r_dup_got;
    logic                r_qed_done;
    logic                r_qed_check;

    logic [SEQ_W-1:0]    w_seq_gap;
    logic                w_in_fire;
    logic                w_out_fire;
    logic [CNT_W-1:0]    w_in_cnt_nxt;
    logic [CNT_W-1:0]    w_out_cnt_nxt;
    logic                w_roll;

    // Allows depend only on registered state and depth, never on the valids.
    assign w_seq_gap     = r_in_seq - r_out_seq;
    assign in_allow      = (r_in_cnt < depth) && (w_seq_gap < C_SEQ_MAX);
    assign out_allow     = (r_out_cnt < depth) && (r_out_seq != r_in_seq);

    assign w_in_fire     = clk_en && in_valid && in_allow;
    assign w_out_fire    = clk_en && out_valid && out_allow;
    assign w_in_cnt_nxt  = r_in_cnt + {{(CNT_W-1){1'b0}}, w_in_fire};
    assign w_out_cnt_nxt = r_out_cnt + {{(CNT_W-1){1'b0}}, w_out_fire};
    assign w_roll        = (w_in_cnt_nxt == depth) && (w_out_cnt_nxt == depth);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_in_seq    <= '0;
            r_out_seq   <= '0;
            r_orig_data <= '0;
            r_orig_seq  <= '0;
            r_dup_seq   <= '0;
            r_orig_out  <= '0;
            r_dup_out   <= '0;
            r_orig_got  <= 1'b0;
            r_dup_got   <= 1'b0;
            r_qed_done  <= 1'b0;
            r_qed_check <= 1'b1;
        end else if (clk_en) begin
            r_in_cnt  <= w_roll ? '0 : w_in_cnt_nxt;
            r_out_cnt <= w_roll ? '0 : w_out_cnt_nxt;
            if (w_in_fire)  r_in_seq  <= r_in_seq + 1'b1;
            if (w_out_fire) r_out_seq <= r_out_seq + 1'b1;

            // Output capture is live from ORIG entry until the pair completes.
            if ((r_state == S_ORIG) || (r_state == S_DUP)) begin
                if (w_out_fire && !r_orig_got && (r_out_seq == r_orig_seq)) begin
                    r_orig_out <= out_data;
                    r_orig_got <= 1'b1;
                end
            end
            if ((r_state == S_DUP) && w_out_fire && !r_dup_got && (r_out_seq == r_dup_seq)) begin
                r_dup_out <= out_data;
                r_dup_got <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_in_fire && exec_orig) begin
                        r_state     <= S_ORIG;
                        r_orig_data <= in_data;
                        r_orig_seq  <= r_in_seq;
                    end
                end
                S_ORIG: begin
                    if (w_in_fire && exec_dup && (in_data == r_orig_data)) begin
                        r_state   <= S_DUP;
                        r_dup_seq <= r_in_seq;
                    end
                end
                S_DUP: begin
                    if (r_orig_got && r_dup_got) begin
                        r_state     <= S_DONE;
                        r_qed_done  <= 1'b1;
                        r_qed_check <= (r_orig_out == r_dup_out);
                    end
                end
                default: r_state <= S_DONE;
            endcase
        end
    end

    assign in_cnt    = r_in_cnt;
    assign out_cnt   = r_out_cnt;
    assign fsm_state = r_state;
    assign qed_done  = r_qed_done;
    assign qed_check = r_qed_check;

endmodule

`default_nettype wire

// File: tb/tb_aqed_fc_tracker.sv
// ============================================================================
// Module   : tb_aqed_fc_tracker
// Purpose  : Directed self-checking bench for aqed_fc_tracker (SEQ_W=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aqed_fc_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [15:0] depth;
    logic        in_valid;
    logic [15:0] in_data;
    logic        exec_orig;
    logic        exec_dup;
    logic        out_valid;
    logic [15:0] out_data;
    logic        in_allow;
    logic        out_allow;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;
    logic [1:0]  fsm_state;
    logic        qed_done;
    logic        qed_check;

    int checks   = 0;
    int failures = 0;

    aqed_fc_tracker #(.DATA_W(16), .CNT_W(16), .SEQ_W(3)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .depth     (depth),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .exec_orig (exec_orig),
        .exec_dup  (exec_dup),
        .out_valid (out_valid),
        .out_data  (out_data),
        .in_allow  (in_allow),
        .out_allow (out_allow),
        .in_cnt    (in_cnt),
        .out_cnt   (out_cnt),
        .fsm_state (fsm_state),
        .qed_done  (qed_done),
        .qed_check (qed_check)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic iv, input logic [15:0] id, input logic eo, input logic ed,
                        input logic ov, input logic [15:0] od);
        in_valid  = iv;
        in_data   = id;
        exec_orig = eo;
        exec_dup  = ed;
        out_valid = ov;
        out_data  = od;
        step();
        in_valid  = 1'b0;
        out_valid = 1'b0;
        exec_orig = 1'b0;
        exec_dup  = 1'b0;
    endtask

    task automatic do_reset(input logic [15:0] d);
        reset     = 1'b0;
        clk_en    = 1'b1;
        depth     = d;
        in_valid  = 1'b0;
        in_data   = '0;
        exec_orig = 1'b0;
        exec_dup  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(16'd3);
        checks++; if (in_cnt !== 16'd0) begin failures++; $display("FAIL rst_in_cnt got=%0d exp=0", in_cnt); end
        checks++; if (out_cnt !== 16'd0) begin failures++; $display("FAIL rst_out_cnt got=%0d exp=0", out_cnt); end
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", fsm_state); end
        checks++; if (qed_done !== 1'b0) begin failures++; $display("FAIL rst_qed_done got=%b exp=0", qed_done); end
        checks++; if (qed_check !== 1'b1) begin failures++; $display("FAIL rst_qed_check got=%b exp=1", qed_check); end
        checks++; if (in_allow !== 1'b1) begin failures++; $display("FAIL rst_in_allow got=%b exp=1", in_allow); end
        checks++; if (out_allow !== 1'b0) begin failures++; $display("FAIL rst_out_allow got=%b exp=0", out_allow); end
    endtask

    task automatic test_depth_zero();
        do_reset(16'd0);
        beat(1'b1, 16'h00AB, 1'b1, 1'b0, 1'b1, 16'h0);
        checks++; if (in_allow !== 1'b0) begin failures++; $display("FAIL d0_in_allow got=%b exp=0", in_allow); end
        checks++; if (out_allow !== 1'b0) begin failures++; $display("FAIL d0_out_allow got=%b exp=0", out_allow); end
        checks++; if (in_cnt !== 16'd0) begin failures++; $display("FAIL d0_in_cnt got=%0d exp=0", in_cnt); end
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL d0_state got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_clk_en();
        do_reset(16'd3);
        clk_en = 1'b0;
        beat(1'b1, 16'h00AB, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++; if (in_cnt !== 16'd0) begin failures++; $display("FAIL cen_in_cnt got=%0d exp=0", in_cnt); end
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL cen_state got=%0d exp=0", fsm_state); end
        checks++; if (in_allow !== 1'b1) begin failures++; $display("FAIL cen_in_allow got=%b exp=1", in_allow); end
        clk_en = 1'b1;
    endtask

    task automatic test_rollover();
        do_reset(16'd3);
        for (int i = 1; i <= 3; i++) begin
            beat(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 16'h0);
            checks++; if (in_cnt !== 16'(i)) begin failures++; $display("FAIL roll_in_cnt got=%0d exp=%0d", in_cnt, i); end
        end
        checks++; if (in_allow !== 1'b0) begin failures++; $display("FAIL roll_in_allow_full got=%b exp=0", in_allow); end
        beat(1'b1, 16'h9, 1'b0, 1'b0, 1'b0, 16'h0);
        checks++; if (in_cnt !== 16'd3) begin failures++; $display("FAIL roll_blocked_in got=%0d exp=3", in_cnt); end
        for (int i = 1; i <= 2; i++) begin
            beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'(i));
            checks++; if (out_cnt !== 16'(i)) begin failures++; $display("FAIL roll_out_cnt got=%0d exp=%0d", out_cnt, i); end
        end
        beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h3);
        checks++; if (in_cnt !== 16'd0) begin failures++; $display("FAIL roll_in_clr got=%0d exp=0", in_cnt); end
        checks++; if (out_cnt !== 16'd0) begin failures++; $display("FAIL roll_out_clr got=%0d exp=0", out_cnt); end
        checks++; if (in_allow !== 1'b1) begin failures++; $display("FAIL roll_in_allow_again got=%b exp=1", in_allow); end
    endtask

    task automatic test_back_to_back();
        do_reset(16'd2);
        beat(1'b1, 16'h1, 1'b0, 1'b0, 1'b0, 16'h0);
        beat(1'b1, 16'h2, 1'b0, 1'b0, 1'b1, 16'h1);
        checks++; if (in_cnt !== 16'd2) begin failures++; $display("FAIL b2b_in_cnt got=%0d exp=2", in_cnt); end
        checks++; if (out_cnt !== 16'd1) begin failures++; $display("FAIL b2b_out_cnt got=%0d exp=1", out_cnt); end
        beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h2);
        checks++; if (in_cnt !== 16'd0 || out_cnt !== 16'd0) begin failures++; $display("FAIL b2b_clr got=%0d/%0d exp=0/0", in_cnt, out_cnt); end
        // Sequences now equal (2,2): nothing left to read.
        checks++; if (out_allow !== 1'b0) begin failures++; $display("FAIL b2b_out_allow got=%b exp=0", out_allow); end
    endtask

    task automatic test_orig_dup(input logic [15:0] dup_out, input logic exp_check);
        do_reset(16'd8);
        beat(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0);
        beat(1'b1, 16'h00AB, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL od_orig_state got=%0d exp=1", fsm_state); end
        beat(1'b1, 16'h00AC, 1'b0, 1'b1, 1'b0, 16'h0);
        checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL od_dup_mismatch_data got=%0d exp=1", fsm_state); end
        beat(1'b1, 16'h00AB, 1'b1, 1'b0, 1'b0, 16'h0);
        beat(1'b1, 16'h00AB, 1'b0, 1'b1, 1'b0, 16'h0);
        checks++; if (fsm_state !== 2'd2) begin failures++; $display("FAIL od_dup_state got=%0d exp=2", fsm_state); end
        beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1111);
        beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234);
        beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h2222);
        beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h3333);
        beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, dup_out);
        checks++; if (qed_done !== 1'b0) begin failures++; $display("FAIL od_done_early got=%b exp=0", qed_done); end
        step();
        checks++; if (qed_done !== 1'b1) begin failures++; $display("FAIL od_done got=%b exp=1", qed_done); end
        checks++; if (qed_check !== exp_check) begin failures++; $display("FAIL od_check got=%b exp=%b", qed_check, exp_check); end
        checks++; if (fsm_state !== 2'd3) begin failures++; $display("FAIL od_done_state got=%0d exp=3", fsm_state); end
        step();
        step();
        checks++; if (qed_done !== 1'b1 || qed_check !== exp_check) begin failures++; $display("FAIL od_sticky got=%b/%b exp=1/%b", qed_done, qed_check, exp_check); end
    endtask

    task automatic test_guards();
        do_reset(16'd3);
        beat(1'b1, 16'h0055, 1'b1, 1'b1, 1'b0, 16'h0);
        checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL guard_both_marks got=%0d exp=1", fsm_state); end
        beat(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0, 16'h0);
        checks++; if (fsm_state !== 2'd2) begin failures++; $display("FAIL guard_to_dup got=%0d exp=2", fsm_state); end
        reset = 1'b0;
        clk_en = 1'b0;
        step();
        reset = 1'b1;
        clk_en = 1'b1;
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL guard_reset_state got=%0d exp=0", fsm_state); end
        checks++; if (qed_check !== 1'b1 || in_cnt !== 16'd0) begin failures++; $display("FAIL guard_reset_regs got=%b/%0d exp=1/0", qed_check, in_cnt); end
    endtask

    task automatic test_seq_wrap();
        do_reset(16'd32);
        // One full lap plus six: both sequence counters sit at 6.
        for (int i = 0; i < 14; i++) begin
            beat(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
            beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0);
        end
        beat(1'b1, 16'h0077, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) beat(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        checks++; if (in_allow !== 1'b0) begin failures++; $display("FAIL wrap_in_allow_full got=%b exp=0", in_allow); end
        beat(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        checks++; if (in_cnt !== 16'd21) begin failures++; $display("FAIL wrap_blocked_in got=%0d exp=21", in_cnt); end
        beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h9999);
        checks++; if (in_allow !== 1'b1) begin failures++; $display("FAIL wrap_in_allow_drain got=%b exp=1", in_allow); end
        beat(1'b1, 16'h0077, 1'b0, 1'b1, 1'b0, 16'h0);
        checks++; if (fsm_state !== 2'd2) begin failures++; $display("FAIL wrap_dup_state got=%0d exp=2", fsm_state); end
        for (int i = 0; i < 6; i++) beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'(16'h0100 + i));
        beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h9999);
        step();
        checks++; if (qed_done !== 1'b1 || qed_check !== 1'b1) begin failures++; $display("FAIL wrap_match got=%b/%b exp=1/1", qed_done, qed_check); end
    endtask

    initial begin
        test_reset();
        test_depth_zero();
        test_clk_en();
        test_rollover();
        test_back_to_back();
        test_orig_dup(16'h1234, 1'b1);
        test_orig_dup(16'h1235, 1'b0);
        test_guards();
        test_seq_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
